// File: rtl/led_digit_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : led_digit_sequencer_if
// Brief    : Value-load handshake and LED display bundle for the digit sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface led_digit_sequencer_if;
    logic [15:0] value_bcd;
    logic        value_valid;
    logic        value_ready;
    logic [0:7]  led;
    logic [1:0]  digit_idx;
    logic        frame_done;

    modport master (
        output value_bcd,
        output value_valid,
        input  value_ready,
        input  led,
        input  digit_idx,
        input  frame_done
    );

    modport slave (
        input  value_bcd,
        input  value_valid,
        output value_ready,
        output led,
        output digit_idx,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/led_digit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_digit_sequencer
// Brief    : Shows four captured BCD digits one at a time on a 7-segment LED
//            with timed dwell and blank gaps, pulsing frame_done at the end.
// Revision : 1.0 - initial release
// ============================================================================
module led_digit_sequencer #(
    parameter int ms_limit = 100000,
    parameter int dwell_ms = 500,
    parameter int gap_ms   = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    led_digit_sequencer_if.slave  bus
);

    localparam int c_MS_MAX   = (dwell_ms > gap_ms) ? dwell_ms : gap_ms;
    localparam int c_PRESC_W  = (ms_limit > 1) ? $clog2(ms_limit) : 1;
    localparam int c_MS_W     = (c_MS_MAX > 1) ? $clog2(c_MS_MAX) : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_ZERO   = '0;
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE    = c_PRESC_W'(1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST   = c_PRESC_W'(ms_limit - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_PENULT = c_PRESC_W'(ms_limit - 2);
    localparam logic [c_MS_W-1:0]    c_MS_ZERO      = '0;
    localparam logic [c_MS_W-1:0]    c_MS_ONE       = c_MS_W'(1);
    localparam logic [c_MS_W-1:0]    c_DWELL_LAST   = c_MS_W'(dwell_ms - 1);
    localparam logic [c_MS_W-1:0]    c_GAP_LAST     = c_MS_W'(gap_ms - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 r_state_q,  w_state_d;
    logic [c_PRESC_W-1:0]   r_presc_q,  w_presc_d;
    logic [c_MS_W-1:0]      r_ms_q,     w_ms_d;
    logic [1:0]             r_idx_q,    w_idx_d;
    logic [15:0]            r_value_q,  w_value_d;
    logic [0:7]             r_led_q,    w_led_d;
    logic                   r_done_q,   w_done_d;
    logic                   r_ready_q,  w_ready_d;

    logic                   w_tick;
    logic                   w_ms_last;
    logic                   w_phase_end;
    logic                   w_transfer;

    // Segment order a,b,c,d,e,f,g,dp from left to right; non-BCD shows dp only.
    function automatic logic [0:7] seg7(input logic [3:0] n);
        logic [0:7] s;
        case (n)
            4'd0:    s = 8'b1111_1100;
            4'd1:    s = 8'b0110_0000;
            4'd2:    s = 8'b1101_1010;
            4'd3:    s = 8'b1111_0010;
            4'd4:    s = 8'b0110_0110;
            4'd5:    s = 8'b1011_0110;
            4'd6:    s = 8'b1011_1110;
            4'd7:    s = 8'b1110_0000;
            4'd8:    s = 8'b1111_1110;
            4'd9:    s = 8'b1111_0110;
            default: s = 8'b0000_0001;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd3:    n = v[15:12];
            2'd2:    n = v[11:8];
            2'd1:    n = v[7:4];
            default: n = v[3:0];
        endcase
        return n;
    endfunction

    always_comb begin
        w_state_d  = r_state_q;
        w_presc_d  = r_presc_q;
        w_ms_d     = r_ms_q;
        w_idx_d    = r_idx_q;
        w_value_d  = r_value_q;
        w_led_d    = r_led_q;
        w_done_d   = 1'b0;
        w_ready_d  = r_ready_q;

        w_tick      = (r_presc_q == c_PRESC_LAST);
        w_ms_last   = (r_state_q == ST_SHOW) ? (r_ms_q == c_DWELL_LAST)
                                             : (r_ms_q == c_GAP_LAST);
        w_phase_end = w_tick && w_ms_last;
        w_transfer  = bus.value_valid && r_ready_q;

        if (r_state_q != ST_IDLE) begin
            w_presc_d = w_tick ? c_PRESC_ZERO : (r_presc_q + c_PRESC_ONE);
            w_ms_d    = w_tick ? (r_ms_q + c_MS_ONE) : r_ms_q;
        end

        case (r_state_q)
            ST_IDLE: begin
                w_presc_d = c_PRESC_ZERO;
                w_ms_d    = c_MS_ZERO;
                w_led_d   = 8'b0;
                w_ready_d = 1'b1;
                if (w_transfer) begin
                    w_value_d = bus.value_bcd;
                    w_idx_d   = 2'd3;
                    w_led_d   = seg7(bus.value_bcd[15:12]);
                    w_ready_d = 1'b0;
                    w_state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_phase_end) begin
                    w_presc_d = c_PRESC_ZERO;
                    w_ms_d    = c_MS_ZERO;
                    w_led_d   = 8'b0;
                    w_state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Registered pulse must land on the final GAP cycle, so look one cycle ahead.
                if (r_idx_q == 2'd0 && r_ms_q == c_GAP_LAST && r_presc_q == c_PRESC_PENULT) begin
                    w_done_d = 1'b1;
                end
                if (w_phase_end) begin
                    w_presc_d = c_PRESC_ZERO;
                    w_ms_d    = c_MS_ZERO;
                    if (r_idx_q != 2'd0) begin
                        w_idx_d   = r_idx_q - 2'd1;
                        w_led_d   = seg7(nibble(r_value_q, r_idx_q - 2'd1));
                        w_state_d = ST_SHOW;
                    end else begin
                        w_ready_d = 1'b1;
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                w_presc_d = c_PRESC_ZERO;
                w_ms_d    = c_MS_ZERO;
                w_led_d   = 8'b0;
                w_ready_d = 1'b1;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_presc_q <= c_PRESC_ZERO;
            r_ms_q    <= c_MS_ZERO;
            r_idx_q   <= 2'd0;
            r_value_q <= 16'h0000;
            r_led_q   <= 8'b0;
            r_done_q  <= 1'b0;
            r_ready_q <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_presc_q <= w_presc_d;
            r_ms_q    <= w_ms_d;
            r_idx_q   <= w_idx_d;
            r_value_q <= w_value_d;
            r_led_q   <= w_led_d;
            r_done_q  <= w_done_d;
            r_ready_q <= w_ready_d;
        end
    end

    // Ready is masked by rst so it reads 0 during reset yet 1 on the very first cycle after release.
    assign bus.value_ready = r_ready_q & ~rst;
    assign bus.led         = r_led_q;
    assign bus.digit_idx   = r_idx_q;
    assign bus.frame_done  = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_digit_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_led_digit_sequencer
// Brief    : Directed table-driven bench for led_digit_sequencer (4/2/1 timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_digit_sequencer;

    localparam int c_MS = 4;
    localparam int c_DW = 2;
    localparam int c_GP = 1;

    typedef struct {
        logic [15:0] value;
        logic [31:0] segs;   // expected led per digit, shown-first digit in [31:24]
        int          mode;   // 0 idle input, 1 ignored load mid-frame, 2 hold valid into next frame
        logic [15:0] alt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [4];

    led_digit_sequencer_if bus_if ();

    led_digit_sequencer #(
        .ms_limit (c_MS),
        .dwell_ms (c_DW),
        .gap_ms   (c_GP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // {led[0:7], digit_idx, frame_done, value_ready}
    function automatic logic [11:0] obs();
        return {bus_if.led, bus_if.digit_idx, bus_if.frame_done, bus_if.value_ready};
    endfunction

    task automatic load(input logic [15:0] v, input string tag);
        bus_if.value_valid = 1'b1;
        bus_if.value_bcd   = v;
        chk({tag, " ready_before_load"}, {15'd0, bus_if.value_ready}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        bus_if.value_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] segs, input int mode,
                             input logic [15:0] alt, input string tag);
        for (int c = 1; c <= 48; c++) begin
            int         d;
            int         p;
            logic [7:0] el;
            d = (c - 1) / 12;
            p = (c - 1) % 12;
            if (mode == 2 || (mode == 1 && c >= 2 && c <= 40)) begin
                bus_if.value_valid = 1'b1;
                bus_if.value_bcd   = alt;
            end else begin
                bus_if.value_valid = 1'b0;
            end
            el = (p < 8) ? segs[(3 - d) * 8 +: 8] : 8'h00;
            chk($sformatf("%s cycle%0d", tag, c), {4'h0, obs()},
                {4'h0, el, 2'(3 - d), (c == 48), 1'b0});
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, " idle_after_frame"}, {4'h0, obs()}, {4'h0, 8'h00, 2'd0, 1'b0, 1'b1});
    endtask

    initial begin
        vecs[0] = '{value: 16'h1234, segs: 32'h60DA_F266, mode: 1, alt: 16'h9999};
        vecs[1] = '{value: 16'h5678, segs: 32'hB6BE_E0FE, mode: 0, alt: 16'h0000};
        vecs[2] = '{value: 16'h9C0E, segs: 32'hF601_FC01, mode: 0, alt: 16'h0000};
        vecs[3] = '{value: 16'hA000, segs: 32'h01FC_FCFC, mode: 2, alt: 16'h1234};

        rst                = 1'b1;
        bus_if.value_valid = 1'b0;
        bus_if.value_bcd   = 16'h0000;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("reset_hold%0d", i), {4'h0, obs()}, 16'h0000);
        end
        rst = 1'b0;
        #1;
        chk("ready_after_release", {4'h0, obs()}, {4'h0, 8'h00, 2'd0, 1'b0, 1'b1});
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            load(vecs[i].value, $sformatf("vec%0d", i));
            run_frame(vecs[i].segs, vecs[i].mode, vecs[i].alt, $sformatf("vec%0d", i));
        end

        // valid was held through the previous frame end: accepted in the first ready cycle
        @(posedge clk);
        @(negedge clk);
        bus_if.value_valid = 1'b0;
        run_frame(32'h60DA_F266, 0, 16'h0000, "backtoback");

        // abort during the fifth cycle of the second SHOW
        load(16'h1234, "abort");
        for (int c = 1; c < 17; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_pre", {4'h0, obs()}, {4'h0, 8'hDA, 2'd2, 1'b0, 1'b0});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_reset", {4'h0, obs()}, 16'h0000);
        rst = 1'b0;
        #1;
        chk("abort_ready", {4'h0, obs()}, {4'h0, 8'h00, 2'd0, 1'b0, 1'b1});
        begin
            int stray;
            stray = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (bus_if.frame_done !== 1'b0 || bus_if.led !== 8'h00) stray++;
            end
            chk("abort_no_done", 16'(stray), 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_digit_sequencer.md
LED_DIGIT_SEQUENCER -- requirements
Module: led_digit_sequencer

Interface
REQ-001 SHALL have parameter ms_limit, default 100000, meaning clk cycles per millisecond (100 MHz clk).
REQ-002 SHALL have parameter dwell_ms, default 500, meaning milliseconds each digit is shown.
REQ-003 SHALL have parameter gap_ms, default 100, meaning milliseconds of blank LEDs between digits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port value_bcd, input, 16 bits: four BCD digits; [15:12] is digit 3 (shown first), [3:0] is digit 0.
REQ-007 SHALL have port value_valid, input, 1 bit: value_bcd offered.
REQ-008 SHALL have port value_ready, output, 1 bit: sequencer accepts a value this cycle.
REQ-009 SHALL have port led, output, [0:7]: led[0..6] = segments a..g, led[7] = dp; 1 = lit.
REQ-010 SHALL have port digit_idx, output, 2 bits: index of the digit currently sequenced.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a four-digit frame completes.

Function
REQ-012 SHALL implement states IDLE, SHOW, GAP; all outputs registered.
REQ-013 SHALL assert value_ready only in IDLE; a transfer occurs on a cycle with value_valid=1 and value_ready=1.
REQ-014 On transfer, SHALL capture value_bcd, set digit_idx=3, and enter SHOW; the new led pattern appears on the next cycle.
REQ-015 SHALL ignore value_valid outside IDLE; the captured value stays stable for the whole frame.
REQ-016 SHALL run a ms prescaler counting 0..ms_limit-1 that produces a one-cycle ms tick at ms_limit-1; the prescaler and ms counter clear on every state entry.
REQ-017 In SHOW, led SHALL equal the segment pattern of the captured digit at digit_idx.
REQ-018 SHOW SHALL last exactly dwell_ms*ms_limit cycles and then enter GAP.
REQ-019 In GAP and IDLE, led SHALL be 8'b0.
REQ-020 GAP SHALL last exactly gap_ms*ms_limit cycles.
REQ-021 At GAP end with digit_idx>0, SHALL decrement digit_idx and re-enter SHOW.
REQ-022 At GAP end with digit_idx==0, SHALL pulse frame_done for exactly 1 cycle and enter IDLE.
REQ-023 value_ready SHALL be 0 during the frame_done cycle and 1 on the following cycle.
REQ-024 Segment patterns (lit segments): 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg; dp is 0 for all digits.
REQ-025 A non-BCD nibble (A..F) SHALL display dp only: led = {0,0,0,0,0,0,0,1} in [0:7] order.
REQ-026 Counter widths SHALL cover ms_limit-1 and max(dwell_ms,gap_ms)-1 without wrap; counters never exceed their terminal value.
REQ-027 dwell_ms and gap_ms SHALL each be >= 1, and ms_limit SHALL be >= 2.

Reset
REQ-028 While rst=1, state SHALL be IDLE, led=0, digit_idx=0, frame_done=0, prescaler=0, ms counter=0, and the captured value=0.
REQ-029 value_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-030 rst asserted mid-SHOW or mid-GAP SHALL abort the frame on the next edge without a frame_done pulse.
REQ-031 rst SHALL take priority over a simultaneous transfer.

Verification (ms_limit=4, dwell_ms=2, gap_ms=1: SHOW=8 cycles, GAP=4 cycles)
REQ-032 SHALL cover reset: rst=1 for 3 cycles -> led=0, digit_idx=0, frame_done=0, value_ready=1 on the first cycle after release.
REQ-033 SHALL cover a full frame: load 16'h1234 -> led shows 1 (bc) for 8 cycles, blank for 4, then 2, 3, 4 likewise; frame_done pulses in cycle 48 after the transfer; value_ready=1 in cycle 49.
REQ-034 SHALL cover an ignored load: value_valid=1 with 16'h9999 during SHOW of frame 16'h1234 -> displayed digits unchanged, value_ready=0.
REQ-035 SHALL cover an invalid digit: load 16'hA000 -> first digit shows led[7] only; the remaining three digits show 0 (abcdef).
REQ-036 SHALL cover reset mid-operation: rst pulse at cycle 5 of the second SHOW -> led=0 and IDLE next cycle, no frame_done pulse.
REQ-037 SHALL cover back-to-back loads: value_valid held high across frame end -> no accept in the frame_done cycle; the new value is accepted the next cycle; the next frame starts correctly.
